// File: rtl/irq_pkg.sv
// irq_pkg: channel state encoding and default channel count for irq_pending_latch
package irq_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACTIVE  = 2'd2
  } ch_state_e;
  localparam int NCH_DEFAULT = 4;
endpackage

// File: rtl/irq_channel.sv
// irq_channel: one channel's IDLE/PENDING/ACTIVE state, request history and sticky overflow (edge events when IRQ_EDGE_DETECT_EN, else level)
module irq_channel
  import irq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic take_i,
  input  logic done_i,
  input  logic ovf_clr_i,
  output logic pend_o,
  output logic act_o,
  output logic ovf_o
);
  ch_state_e state_q, state_d;
  logic req_q, ovf_q, ovf_d, rise, ev, busy;
  assign rise = req_i & ~req_q;
`ifdef IRQ_EDGE_DETECT_EN
  assign ev = rise;
`else
  assign ev = req_i;
`endif
  assign busy = (state_q == PENDING) | ((state_q == ACTIVE) & ~done_i);
  always_comb begin
    state_d = (state_q == PENDING) ? (take_i ? ACTIVE : PENDING) :
              (state_q == ACTIVE)  ? (done_i ? (ev ? PENDING : IDLE) : ACTIVE) :
              (ev ? PENDING : IDLE);
    ovf_d = (rise & busy) | (ovf_q & ~ovf_clr_i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_i;
      ovf_q <= ovf_d;
    end
  end
  assign pend_o = state_q == PENDING;
  assign act_o = state_q == ACTIVE;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/irq_pending_latch.sv
// irq_pending_latch: NCH-channel request latch (req_in/mask/take/done/ovf_clr in; pending/active/any_pending/overflow/take_err out); IRQ_EDGE_DETECT_EN selects edge events
module irq_pending_latch
  import irq_pkg::*;
#(
  parameter  int NCH  = NCH_DEFAULT,
  localparam int IDXW = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  req_in,
  input  logic [NCH-1:0]  mask,
  input  logic            take_valid,
  input  logic [IDXW-1:0] take_idx,
  input  logic            done_valid,
  input  logic [IDXW-1:0] done_idx,
  input  logic            ovf_clr,
  output logic [NCH-1:0]  pending,
  output logic [NCH-1:0]  active,
  output logic            any_pending,
  output logic [NCH-1:0]  overflow,
  output logic            take_err
);
  logic [NCH-1:0] take_hit, done_hit, pend_raw;
  logic take_err_q, take_err_d;
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign take_hit[g] = take_valid & (take_idx == IDXW'(g)) & ~mask[g];
    assign done_hit[g] = done_valid & (done_idx == IDXW'(g));
    irq_channel u_ch (
      .clk      (clk),
      .rst      (rst),
      .req_i    (req_in[g]),
      .take_i   (take_hit[g]),
      .done_i   (done_hit[g]),
      .ovf_clr_i(ovf_clr),
      .pend_o   (pend_raw[g]),
      .act_o    (active[g]),
      .ovf_o    (overflow[g])
    );
  end
  assign take_err_d = take_valid & ~|(take_hit & pend_raw);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) take_err_q <= 1'b0;
    else take_err_q <= take_err_d;
  end
  assign pending = pend_raw & ~mask;
  assign any_pending = |pending;
  assign take_err = take_err_q;
endmodule

// File: doc/irq_pending_latch.md
IRQ_PENDING_LATCH -- requirements
Module: irq_pending_latch

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning number of request channels (legal 2..16).
REQ-002 The block SHALL have localparam IDXW, value $clog2(NCH), meaning channel index width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port req_in  input  NCH  raw request lines, one per channel.
REQ-006 The block SHALL have port mask  input  NCH  1 = hide channel from pending output.
REQ-007 The block SHALL have port take_valid  input  1  downstream claims channel take_idx this cycle.
REQ-008 The block SHALL have port take_idx  input  IDXW  channel being claimed.
REQ-009 The block SHALL have port done_valid  input  1  downstream finished servicing done_idx.
REQ-010 The block SHALL have port done_idx  input  IDXW  channel being retired.
REQ-011 The block SHALL have port ovf_clr  input  1  clears all sticky overflow bits.
REQ-012 The block SHALL have port pending  output  NCH  unmasked PENDING channels; drives the downstream priority encoder input.
REQ-013 The block SHALL have port active  output  NCH  channels in ACTIVE state.
REQ-014 The block SHALL have port any_pending  output  1  OR-reduce of pending.
REQ-015 The block SHALL have port overflow  output  NCH  sticky: request event while channel busy.
REQ-016 The block SHALL have port take_err  output  1  registered one-cycle pulse: illegal take.

Function
REQ-017 Each channel SHALL hold a 2-bit state: IDLE, PENDING, ACTIVE.
REQ-018 IDLE -> PENDING SHALL occur on a request event for that channel; no other exit from IDLE.
REQ-019 PENDING -> ACTIVE SHALL occur when take_valid=1 and take_idx=i; otherwise PENDING holds.
REQ-020 ACTIVE -> IDLE SHALL occur when done_valid=1 and done_idx=i; if a request event coincides, ACTIVE -> PENDING instead, no overflow.
REQ-021 A request event on a channel in PENDING, or in ACTIVE without a coinciding done, SHALL set overflow[i]; state unchanged.
REQ-022 pending[i] SHALL equal (state==PENDING) & ~mask[i], combinational from registered state; an event in cycle N is visible in cycle N+1.
REQ-023 mask SHALL affect only pending/any_pending; masked channels still capture events, transition and overflow.
REQ-024 take_valid with take_idx >= NCH, or targeting a channel not in PENDING (including masked-pending), SHALL be ignored and pulse take_err in the next cycle.
REQ-025 done_valid targeting a channel not in ACTIVE, or done_idx >= NCH, SHALL be ignored silently.
REQ-026 take and done on the same channel in the same cycle SHALL apply only the transition legal for the current state.
REQ-027 ovf_clr SHALL clear overflow next cycle; a simultaneous new overflow event SHALL win for that bit.

Reset
REQ-028 rst=1 SHALL asynchronously force all channels IDLE, req_in history to 0, overflow=0, take_err=0; hence pending=0, active=0, any_pending=0.
REQ-029 After reset release, a req_in bit already high SHALL count as a request event in the first clock.

Configuration
REQ-030 With IRQ_EDGE_DETECT_EN defined, a request event SHALL be a rising edge (req_in[i] & ~req_q[i]), req_q a registered copy of req_in.
REQ-031 Without IRQ_EDGE_DETECT_EN, a request event SHALL be req_in[i]==1 (level); a held request re-pends immediately after done and does not flag overflow while PENDING/ACTIVE.

Structure
REQ-032 Package irq_pkg SHALL hold the channel state enum (IDLE=2'd0, PENDING=2'd1, ACTIVE=2'd2) and default NCH constant.
REQ-033 Per-channel logic SHALL be one sub-module irq_channel (state register, event detect, overflow bit), instantiated NCH times via generate.

Verification
REQ-034 Edge mode: req_in 0000->0100 in cycle N -> pending=0100, any_pending=1 in N+1; active=0000.
REQ-035 take_valid=1, take_idx=2 with pending=0100 -> next cycle pending=0000, active=0100; then done_idx=2 -> active=0000.
REQ-036 Channel 1 PENDING, new rising edge on req_in[1] -> overflow=0010 next cycle; ovf_clr=1 -> overflow=0000 following cycle.
REQ-037 mask=1000, rising edge on req_in[3] -> pending=0000; mask cleared -> pending=1000 with no new edge.
REQ-038 take_valid=1, take_idx=0 with channel 0 IDLE -> take_err=1 for exactly one cycle, all states unchanged.
REQ-039 rst asserted mid-operation (pending=0110, active=1000, overflow=0001) -> all outputs 0 immediately, without waiting for clk.
